// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through receive FIFO
module uart_rx_fifo #(
   parameter int BIT_CLKS = 16,
   parameter int FIFO_AW  = 4
) (
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic               rx,
   input  logic               rd_en,
   output logic [7:0]         rd_data,
   output logic               empty,
   output logic               full,
   output logic [FIFO_AW:0]   count,
   output logic               frame_err,
   output logic               overrun,
   input  logic               err_clr
);

   localparam int CW    = $clog2(BIT_CLKS);
   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [2:0]       idx, idx_n;
   logic [7:0]       sh, sh_n;
   logic             push, frame_set;

   logic             rx_m, rx_s, rx_q;
   logic [2:0]       primed;
   logic             fall;

   logic [7:0]       mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic             do_pop, do_push;

   // Two-flop synchronizer plus one delay stage for falling-edge detection.
   // primed tracks which stages hold a real line sample rather than a reset value,
   // so a line that is already low when reset releases is not mistaken for an edge.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         rx_m   <= 1'b1;
         rx_s   <= 1'b1;
         rx_q   <= 1'b1;
         primed <= 3'b000;
      end else begin
         rx_m   <= rx;
         rx_s   <= rx_m;
         rx_q   <= rx_s;
         primed <= {primed[1:0], 1'b1};
      end
   end

   assign fall = primed[2] & rx_q & ~rx_s;

   // Receiver state and datapath registers.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         sh    <= sh_n;
      end
   end

   // Next-state logic: start bit checked at half a bit, data and stop bits mid-bit.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      idx_n     = idx;
      sh_n      = sh;
      push      = 1'b0;
      frame_set = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (fall) state_n = START;
         end
         START: begin
            if (cnt == CW'(BIT_CLKS / 2 - 1)) begin
               cnt_n = '0;
               idx_n = '0;
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CW'(BIT_CLKS - 1)) begin
               sh_n[idx] = rx_s;
               cnt_n     = '0;
               idx_n     = idx + 3'd1;
               if (idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (cnt == CW'(BIT_CLKS - 1)) begin
               cnt_n     = '0;
               state_n   = IDLE;
               push      = rx_s;
               frame_set = ~rx_s;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == (FIFO_AW + 1)'(DEPTH));
   assign do_pop  = rd_en & ~empty;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];

   // FIFO storage; contents need no reset because empty masks rd_data.
   always_ff @(posedge HCLK) begin
      if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= sh;
   end

   // FIFO pointers.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Sticky error flags; a new error outranks a simultaneous clear.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (frame_set)    frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (push & ~do_push) overrun <= 1'b1;
         else if (err_clr)    overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

   localparam int BIT = 16;
   localparam int AW  = 2;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic          rx;
   logic          rd_en;
   logic [7:0]    rd_data;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          frame_err;
   logic          overrun;
   logic          err_clr;

   int            errors = 0;
   int            checks = 0;
   logic [7:0]    sb[$];

   uart_rx_fifo #(.BIT_CLKS(BIT), .FIFO_AW(AW)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
      .empty(empty), .full(full), .count(count), .frame_err(frame_err),
      .overrun(overrun), .err_clr(err_clr)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      clks(BIT);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_val);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_val);
      rx = 1'b1;
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] exp;
      check({tag, "_nonempty"}, 32'(empty), 32'd0);
      if (sb.size() == 0) begin
         check({tag, "_scoreboard"}, 32'd0, 32'd1);
         exp = 8'h00;
      end else begin
         exp = sb.pop_front();
      end
      check({tag, "_data"}, 32'(rd_data), 32'(exp));
      rd_en = 1'b1;
      clks(1);
      rd_en = 1'b0;
   endtask

   initial begin
      HRESET  = 1'b1;
      rx      = 1'b1;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      clks(3);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      HRESET = 1'b0;
      clks(5);

      // T1: single byte
      send_byte(8'h41, 1'b1); sb.push_back(8'h41);
      clks(4);
      check("t1_count", 32'(count), 32'd1);
      check("t1_flags", 32'({frame_err, overrun}), 32'd0);
      pop_check("t1_pop");
      check("t1_empty", 32'(empty), 32'd1);

      // T2: back-to-back bytes, then pops
      send_byte(8'h48, 1'b1); sb.push_back(8'h48);
      send_byte(8'h69, 1'b1); sb.push_back(8'h69);
      send_byte(8'h0A, 1'b1); sb.push_back(8'h0A);
      clks(4);
      check("t2_count", 32'(count), 32'd3);
      pop_check("t2_pop0");
      pop_check("t2_pop1");
      pop_check("t2_pop2");
      check("t2_empty", 32'(empty), 32'd1);
      rd_en = 1'b1; clks(1); rd_en = 1'b0;
      check("t2_pop_on_empty", 32'(count), 32'd0);

      // T3: short low glitch is rejected
      rx = 1'b0; clks(5); rx = 1'b1;
      clks(12 * BIT);
      check("t3_empty", 32'(empty), 32'd1);
      check("t3_frame_err", 32'(frame_err), 32'd0);

      // T4: framing error then clear
      send_byte(8'h55, 1'b0);
      clks(4);
      check("t4_frame_err", 32'(frame_err), 32'd1);
      check("t4_count", 32'(count), 32'd0);
      err_clr = 1'b1; clks(1); err_clr = 1'b0;
      check("t4_cleared", 32'(frame_err), 32'd0);

      // T5: overflow a depth-4 FIFO
      for (int i = 1; i <= 5; i++) begin
         send_byte(8'(i), 1'b1);
         if (i <= 4) sb.push_back(8'(i));
      end
      clks(4);
      check("t5_full", 32'(full), 32'd1);
      check("t5_count", 32'(count), 32'd4);
      check("t5_overrun", 32'(overrun), 32'd1);
      check("t5_frame_err", 32'(frame_err), 32'd0);
      for (int i = 0; i < 4; i++) pop_check("t5_pop");
      check("t5_empty", 32'(empty), 32'd1);
      check("t5_overrun_sticky", 32'(overrun), 32'd1);
      err_clr = 1'b1; clks(1); err_clr = 1'b0;
      check("t5_overrun_clr", 32'(overrun), 32'd0);

      // T6: reset mid-frame with the line held low across release
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rx = 1'b0;
      HRESET = 1'b1; clks(2);
      check("t6_rst_empty", 32'(empty), 32'd1);
      HRESET = 1'b0;
      clks(3 * BIT);
      rx = 1'b1;
      clks(2 * BIT);
      check("t6_low_no_frame", 32'(empty), 32'd1);
      send_byte(8'h3C, 1'b1); sb.push_back(8'h3C);
      clks(4);
      check("t6_count", 32'(count), 32'd1);
      check("t6_flags", 32'({frame_err, overrun}), 32'd0);
      pop_check("t6_pop");
      check("t6_empty", 32'(empty), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
